// File: rtl/truth_table_scanner.sv
// Walks every input vector through two implementations of one function and captures both truth tables.
// Optional STOP_ON_MISMATCH_EN: end the scan on the first disagreeing sample instead of finishing the sweep.
module truth_table_scanner #(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_IN-1:0]       x,
    input  logic                  a_in,
    input  logic                  b_in,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_a,
    output logic [(1<<N_IN)-1:0]  table_b,
    output logic                  mismatch,
    output logic [N_IN-1:0]       first_bad
);

    localparam int unsigned TW       = 1 << N_IN;
    localparam int unsigned CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] X_LAST = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [N_IN-1:0] x_next, first_bad_next;
    logic [TW-1:0]   table_a_next, table_b_next;
    logic            busy_next, done_next, mismatch_next;
    logic            scan_end;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            x         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_a   <= '0;
            table_b   <= '0;
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            x         <= x_next;
            busy      <= busy_next;
            done      <= done_next;
            table_a   <= table_a_next;
            table_b   <= table_b_next;
            mismatch  <= mismatch_next;
            first_bad <= first_bad_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        x_next         = x;
        busy_next      = busy;
        done_next      = 1'b0;
        table_a_next   = table_a;
        table_b_next   = table_b;
        mismatch_next  = mismatch;
        first_bad_next = first_bad;
        scan_end       = 1'b0;

        case (state)
            IDLE, DONE: begin
                busy_next = 1'b0;
                x_next    = '0;
                if (state == DONE) state_next = IDLE;
                // DONE accepts start too, so scans can run back to back
                if (start) begin
                    table_a_next   = '0;
                    table_b_next   = '0;
                    mismatch_next  = 1'b0;
                    first_bad_next = '0;
                    cnt_next       = CNT_LOAD;
                    busy_next      = 1'b1;
                    state_next     = SCAN;
                end
            end
            SCAN: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    table_a_next[x] = a_in;
                    table_b_next[x] = b_in;
                    if ((a_in != b_in) && !mismatch) begin
                        mismatch_next  = 1'b1;
                        first_bad_next = x;
                    end
                    scan_end = (x == X_LAST);
`ifdef STOP_ON_MISMATCH_EN
                    scan_end = scan_end | (a_in != b_in);
`else
                    scan_end = scan_end | 1'b0;
`endif
                    if (scan_end) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        x_next     = '0;
                    end else begin
                        x_next   = x + 1'b1;
                        cnt_next = CNT_LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed scoreboard bench for truth_table_scanner: default instance (N_IN=2, SETTLE=2) and a (3,1) instance.
module tb_truth_table_scanner;

    localparam int unsigned S0 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    int   mode = 0;

    logic [1:0] x0, fb0;
    logic [3:0] ta0, tb0;
    logic       a0, b0, busy0, done0, mm0;
    logic [2:0] x1, fb1;
    logic [7:0] ta1, tb1;
    logic       a1, b1, busy1, done1, mm1;

    always #5 clk = ~clk;

    // A is always NAND; B is NAND (mode 0) or AND (mode 1)
    always_comb begin
        a0 = ~(x0[1] & x0[0]);
        b0 = (mode == 1) ? (x0[1] & x0[0]) : ~(x0[1] & x0[0]);
        a1 = x1[0];
        b1 = x1[0];
    end

    truth_table_scanner #(.N_IN(2), .SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x(x0), .a_in(a0), .b_in(b0),
        .busy(busy0), .done(done0), .table_a(ta0), .table_b(tb0),
        .mismatch(mm0), .first_bad(fb0)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .table_a(ta1), .table_b(tb1),
        .mismatch(mm1), .first_bad(fb1)
    );

    typedef struct {
        logic [7:0] ta;
        logic [7:0] tb;
        logic       mm;
        logic [2:0] fb;
        int         cycles;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference for the N_IN=2, SETTLE=2 instance
    function automatic exp_t model0(input int m);
        exp_t e;
        bit a, b;
        e.ta = '0; e.tb = '0; e.mm = 1'b0; e.fb = '0; e.cycles = 4 * S0;
        for (int i = 0; i < 4; i++) begin
            a = !(((i & 1) != 0) && ((i & 2) != 0));
            b = (m == 1) ? !a : a;
            e.ta[i] = a;
            e.tb[i] = b;
            if (a != b && !e.mm) begin
                e.mm = 1'b1;
                e.fb = 3'(i);
`ifdef STOP_ON_MISMATCH_EN
                e.cycles = (i + 1) * S0;
                break;
`endif
            end
        end
        return e;
    endfunction

    // Called at a negedge; start is sampled on the next posedge
    task automatic go0();
        start0 = 1'b1;
        @(posedge clk); @(negedge clk);
        start0 = 1'b0;
        check("accept_busy", 32'(busy0), 32'd1);
        check("accept_x", 32'(x0), 32'd0);
    endtask

    task automatic wait_done0(input string tag, input int pulse_at, input bit hold_end);
        exp_t e;
        bit   seen;
        int   ncyc;
        seen = 1'b0;
        ncyc = sb[0].cycles;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); @(negedge clk);
            if (pulse_at == c) start0 = 1'b1;
            else if (pulse_at == c - 1) start0 = 1'b0;
            if (hold_end && c == ncyc - 1) start0 = 1'b1;
            if (done0) begin
                seen = 1'b1;
                e = sb.pop_front();
                check({tag, "_cycles"}, 32'(c), 32'(e.cycles));
                check({tag, "_busy_end"}, 32'(busy0), 32'd0);
                check({tag, "_x_end"}, 32'(x0), 32'd0);
                check({tag, "_table_a"}, 32'(ta0), 32'(e.ta));
                check({tag, "_table_b"}, 32'(tb0), 32'(e.tb));
                check({tag, "_mismatch"}, 32'(mm0), 32'(e.mm));
                check({tag, "_first_bad"}, 32'(fb0), 32'(e.fb));
            end else if (c < ncyc) begin
                check({tag, "_x_step"}, 32'(x0), 32'(c / S0));
                check({tag, "_busy"}, 32'(busy0), 32'd1);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        exp_t e1;
        bit   seen1;

        // Asynchronous reset assertion with no clock edge involved
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_x", 32'(x0), 32'd0);
        check("rst_tables", 32'({ta0, tb0}), 32'd0);
        check("rst_mismatch", 32'(mm0), 32'd0);
        check("rst_first_bad", 32'(fb0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Matching pair: NAND vs NAND
        mode = 0;
        sb.push_back(model0(0));
        go0();
        wait_done0("match", 0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("match_done_pulse", 32'(done0), 32'd0);
        check("match_hold_a", 32'(ta0), 32'h7);

        // NAND vs AND
        mode = 1;
        sb.push_back(model0(1));
        go0();
        wait_done0("mism", 0, 1'b0);
        repeat (3) @(negedge clk);
        check("mism_hold_mm", 32'(mm0), 32'd1);
        check("mism_hold_b", 32'(tb0), 32'(sb.size() == 0 ? model0(1).tb : 8'h0));

        // Reset in the middle of a scan
        go0();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_x", 32'(x0), 32'd0);
        check("midrst_tables", 32'({ta0, tb0}), 32'd0);
        check("midrst_mismatch", 32'(mm0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_idle_busy", 32'(busy0), 32'd0);
        check("midrst_idle_x", 32'(x0), 32'd0);

        // Start pulsed while busy is ignored
        mode = 0;
        sb.push_back(model0(0));
        go0();
        wait_done0("busy_pulse", 3, 1'b0);
        @(negedge clk);

        // Start held through done launches a second scan from DONE
        mode = 1;
        sb.push_back(model0(1));
        go0();
        wait_done0("b2b_first", 0, 1'b1);
        sb.push_back(model0(1));
        @(posedge clk); @(negedge clk);
        start0 = 1'b0;
        check("b2b_busy", 32'(busy0), 32'd1);
        check("b2b_done", 32'(done0), 32'd0);
        check("b2b_clear_tables", 32'({ta0, tb0}), 32'd0);
        check("b2b_clear_mm", 32'(mm0), 32'd0);
        wait_done0("b2b_second", 0, 1'b0);

        // N_IN=3, SETTLE=1 instance: x steps every edge
        sb.push_back('{ta: 8'hAA, tb: 8'hAA, mm: 1'b0, fb: 3'd0, cycles: 8});
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        check("n3_accept_busy", 32'(busy1), 32'd1);
        seen1 = 1'b0;
        for (int c = 1; c <= 20 && !seen1; c++) begin
            @(posedge clk); @(negedge clk);
            if (done1) begin
                seen1 = 1'b1;
                e1 = sb.pop_front();
                check("n3_cycles", 32'(c), 32'(e1.cycles));
                check("n3_table_a", 32'(ta1), 32'(e1.ta));
                check("n3_table_b", 32'(tb1), 32'(e1.tb));
                check("n3_mismatch", 32'(mm1), 32'(e1.mm));
                check("n3_x_end", 32'(x1), 32'd0);
            end else if (c < 8) begin
                check("n3_x_step", 32'(x1), 32'(c));
            end
        end
        check("n3_done_seen", 32'(seen1), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
